// File: rtl/regsel_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regsel_pkg
// Purpose : Shared constants and helpers for the register-select scoreboard.
// Revision: 1.0 - initial parametrised release
// ============================================================================
package regsel_pkg;

  localparam int OPC_W     = 5;
  // Ra sits immediately below the opcode; Rb and Rc follow, each IDX_W bits lower.
  localparam int RA_OFS    = OPC_W;
  localparam int MAX_REGS  = 32;

  function automatic logic [MAX_REGS-1:0] onehot(input logic [4:0] idx);
    logic [MAX_REGS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regsel_onehot_dec.sv
`default_nettype none
// ============================================================================
// Module  : regsel_onehot_dec
// Purpose : IDX_W-bit index to 2**IDX_W one-hot decoder.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module regsel_onehot_dec #(
  parameter int IDX_W = 4
) (
  input  logic [IDX_W-1:0]        idx,
  output logic [(1<<IDX_W)-1:0]   dec
);

  for (genvar i = 0; i < (1 << IDX_W); i++) begin : g_bit
    assign dec[i] = (idx == IDX_W'(i));
  end

endmodule
`default_nettype wire

// File: rtl/regsel_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : regsel_scoreboard
// Purpose : Instruction latch, Ra/Rb/Rc strobe decode, immediate sign-extend
//           and per-register busy scoreboard with hazard stall.
// Revision: 1.0 - initial parametrised release
// ============================================================================
module regsel_scoreboard
  import regsel_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32,
  parameter int DATA_W   = 32,
  parameter int IMM_W    = 19,
  parameter int LINK_REG = NUM_REGS - 1,
  parameter bit R0_ZERO  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ir_load,
  input  logic [IR_W-1:0]             ir_in,
  input  logic                        gra,
  input  logic                        grb,
  input  logic                        grc,
  input  logic                        r_in,
  input  logic                        r_out,
  input  logic                        ba_out,
  input  logic                        link_in,
  input  logic                        reserve,
  input  logic                        commit,
  input  logic [$clog2(NUM_REGS)-1:0] commit_idx,
  output logic [OPC_W-1:0]            opcode,
  output logic [DATA_W-1:0]           imm_sext,
  output logic [NUM_REGS-1:0]         rin_cs,
  output logic [NUM_REGS-1:0]         rout_cs,
  output logic                        ba_zero,
  output logic                        hazard,
  output logic                        sel_err,
  output logic [NUM_REGS-1:0]         busy_vec
);

  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int RA_HI = IR_W - 1 - RA_OFS;
  localparam int RB_HI = RA_HI - IDX_W;
  localparam int RC_HI = RB_HI - IDX_W;

  localparam logic [MAX_REGS-1:0] c_link_oh_full = onehot(5'(LINK_REG));
  localparam logic [NUM_REGS-1:0] c_link_oh      = c_link_oh_full[NUM_REGS-1:0];

  logic [IR_W-1:0]     r_ir;
  logic [NUM_REGS-1:0] r_busy;

  logic [IDX_W-1:0]    w_ra;
  logic [IDX_W-1:0]    w_rb;
  logic [IDX_W-1:0]    w_rc;
  logic [IDX_W-1:0]    w_sel;
  logic [NUM_REGS-1:0] w_dec;
  logic                w_read_req;
  logic                w_r0_base;
  logic                w_hazard;

  assign w_ra = r_ir[RA_HI -: IDX_W];
  assign w_rb = r_ir[RB_HI -: IDX_W];
  assign w_rc = r_ir[RC_HI -: IDX_W];

  assign opcode   = r_ir[IR_W-1 -: OPC_W];
  assign imm_sext = DATA_W'($signed(r_ir[IMM_W-1:0]));
  assign busy_vec = r_busy;

  always_comb begin
    w_sel = '0;
    if (gra)      w_sel = w_ra;
    else if (grb) w_sel = w_rb;
    else if (grc) w_sel = w_rc;
  end

  assign sel_err = (gra & grb) | (gra & grc) | (grb & grc);

  regsel_onehot_dec #(
    .IDX_W (IDX_W)
  ) u_dec (
    .idx (w_sel),
    .dec (w_dec)
  );

  // A base-address read of R0 is served by the bus driving zero, so it never
  // touches the register file and cannot conflict with a pending write.
  assign w_read_req = r_out | ba_out;
  assign w_r0_base  = R0_ZERO && ba_out && (w_sel == '0);

  assign w_hazard = (w_read_req && !w_r0_base && r_busy[w_sel])
                  | (r_in && r_busy[w_sel])
                  | (reserve && r_busy[w_ra]);

  always_comb begin
    rout_cs = '0;
    rin_cs  = link_in ? c_link_oh : '0;
    if (!w_hazard) begin
      if (w_read_req && !w_r0_base) rout_cs = w_dec;
      if (r_in)                     rin_cs  = rin_cs | w_dec;
    end
  end

  assign ba_zero = w_r0_base && !w_hazard;
  assign hazard  = w_hazard;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ir <= '0;
    end else if (ir_load) begin
      r_ir <= ir_in;
    end
  end

  // Set is applied after clear so a same-cycle reserve beats a commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      logic [NUM_REGS-1:0] v_next;
      v_next = r_busy;
      if (commit)                v_next[commit_idx] = 1'b0;
      if (reserve && !w_hazard)  v_next[w_ra]       = 1'b1;
      r_busy <= v_next;
    end
  end

endmodule
`default_nettype wire
